// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM states,
// requester port indices and the default SRAM geometry.
package sram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  localparam int PORT_LOADER = 0;
  localparam int PORT_CORE   = 1;
  localparam int PORT_RECOG  = 2;

  localparam int DEF_AW = 20;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// Combinational round-robin selector: first active request after ptr,
// wrapping modulo N, as one-hot grant plus binary index.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int k;
    k     = 0;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // ptr itself is scanned last, so the previous winner has lowest priority
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Serialises NPORTS requesters onto one SRAM controller: round-robin with
// bounded burst lock, one access in flight, per-access timeout.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NPORTS    = 3,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int TIMEOUT   = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NPORTS-1:0]    i_req,
  input  logic [NPORTS-1:0]    i_wr,
  input  logic [NPORTS-1:0]    i_lock,
  input  logic [NPORTS*AW-1:0] i_addr,
  input  logic [NPORTS*DW-1:0] i_wdata,
  output logic [NPORTS-1:0]    o_gnt,
  output logic [NPORTS-1:0]    o_done,
  output logic                 o_err,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_busy,
  output logic                 o_m_req,
  output logic                 o_m_wr,
  output logic [AW-1:0]        o_m_addr,
  output logic [DW-1:0]        o_m_wdata,
  input  logic                 i_m_wait,
  input  logic                 i_m_valid,
  input  logic [DW-1:0]        i_m_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t        state;
  logic [IW-1:0]     ptr, win, owner, rr_idx, pick_idx;
  logic [NPORTS-1:0] rr_gnt, pick_oh;
  logic              rr_found, lock_vld, lock_take;
  logic [BW-1:0]     burst_cnt;
  logic [TW-1:0]     tmo_cnt;

  rr_picker #(.N(NPORTS), .IW(IW)) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // An exhausted burst falls through to round-robin for one arbitration
  assign lock_take = lock_vld && i_req[owner] && (burst_cnt < BW'(MAX_BURST));
  assign pick_idx  = lock_take ? owner : rr_idx;
  assign pick_oh   = lock_take ? (NPORTS'(1) << owner) : rr_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ptr       <= IW'(NPORTS - 1);
      win       <= '0;
      owner     <= '0;
      lock_vld  <= 1'b0;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      o_gnt     <= '0;
      o_done    <= '0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
      o_busy    <= 1'b0;
      o_m_req   <= 1'b0;
      o_m_wr    <= 1'b0;
      o_m_addr  <= '0;
      o_m_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_m_wait && rr_found) begin
            win       <= pick_idx;
            o_m_wr    <= i_wr[pick_idx];
            o_m_addr  <= i_addr[int'(pick_idx)*AW +: AW];
            o_m_wdata <= i_wdata[int'(pick_idx)*DW +: DW];
            o_gnt     <= pick_oh;
            o_m_req   <= 1'b1;
            o_busy    <= 1'b1;
            if (burst_cnt >= BW'(MAX_BURST)) burst_cnt <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          o_gnt   <= '0;
          o_m_req <= 1'b0;
          ptr     <= win;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (i_m_valid) begin
            if (!o_m_wr) o_rdata <= i_m_rdata;
            o_err  <= 1'b0;
            o_done <= NPORTS'(1) << win;
            state  <= DONE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            o_err  <= 1'b1;
            o_done <= NPORTS'(1) << win;
            state  <= DONE;
          end
        end
        DONE: begin
          o_done  <= '0;
          o_err   <= 1'b0;
          o_busy  <= 1'b0;
          tmo_cnt <= '0;
          state   <= IDLE;
          if (i_lock[win]) begin
            if (lock_vld && owner == win) begin
              burst_cnt <= burst_cnt + BW'(1);
            end else begin
              owner     <= win;
              lock_vld  <= 1'b1;
              burst_cnt <= BW'(1);
            end
          end else begin
            lock_vld  <= 1'b0;
            burst_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: directed sequences push expected grants/completions,
// a negedge monitor pops and compares whenever o_gnt or o_done fires.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int NP  = 3;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int TMO = 16;
  localparam int MB  = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [NP-1:0]     i_req, i_wr, i_lock;
  logic [NP*AW-1:0]  i_addr;
  logic [NP*DW-1:0]  i_wdata;
  logic [NP-1:0]     o_gnt, o_done;
  logic              o_err, o_busy, o_m_req, o_m_wr;
  logic [DW-1:0]     o_rdata, o_m_wdata;
  logic [AW-1:0]     o_m_addr;
  logic              i_m_wait, i_m_valid;
  logic [DW-1:0]     i_m_rdata;

  sram_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TMO), .MAX_BURST(MB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wr(i_wr), .i_lock(i_lock),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_m_req(o_m_req), .o_m_wr(o_m_wr),
    .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata), .i_m_wait(i_m_wait),
    .i_m_valid(i_m_valid), .i_m_rdata(i_m_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int port; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } gnt_t;
  typedef struct { int port; logic err; logic [DW-1:0] rdata; int lat; } done_t;

  gnt_t  gq[$];
  done_t dq[$];
  gnt_t  ge;
  done_t de;
  logic [NP-1:0] oh;

  int n_vec = 0, n_err = 0, cyc = 0, gnt_cyc = 0;
  int left[NP] = '{default: 0};
  logic            pwr[NP];
  logic [AW-1:0]   paddr[NP];
  logic [DW-1:0]   pwdata[NP];
  int  ctl_lat = 3, pend = 0;
  bit  ctl_mute = 0;
  logic [DW-1:0] last_rd;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Requesters (level req held until granted) and controller model
  initial forever begin
    @(negedge i_clk);
    for (int k = 0; k < NP; k++) begin
      if (o_gnt[k] && left[k] > 0) left[k]--;
      i_req[k] = (left[k] > 0);
      i_wr[k]  = pwr[k];
      i_addr[k*AW +: AW]  = paddr[k];
      i_wdata[k*DW +: DW] = pwdata[k];
    end
    i_m_valid = 1'b0;
    i_m_rdata = 16'h5555;
    if (!i_rst_n) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          i_m_valid = 1'b1;
          i_m_rdata = o_m_wr ? 16'hDEAD : (16'h0A00 + DW'(o_m_addr[7:0]));
        end
      end
      if (o_m_req && !ctl_mute) pend = ctl_lat;
    end
  end

  // Monitor
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n) begin
      if (o_gnt != '0) begin
        if (gq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL gnt_unexpected: got o_gnt=%b, required none", o_gnt);
        end else begin
          ge = gq.pop_front();
          oh = NP'(1) << ge.port;
          n_vec++;
          if (o_gnt !== oh || o_m_req !== 1'b1 || o_busy !== 1'b1 || o_m_wr !== ge.wr ||
              o_m_addr !== ge.addr || o_m_wdata !== ge.wdata) begin
            n_err++;
            $display("FAIL gnt_port%0d: got gnt=%b mreq=%b busy=%b wr=%b addr=%h wdata=%h, required gnt=%b mreq=1 busy=1 wr=%b addr=%h wdata=%h",
                     ge.port, o_gnt, o_m_req, o_busy, o_m_wr, o_m_addr, o_m_wdata, oh, ge.wr, ge.addr, ge.wdata);
          end
          if (ge.cyc >= 0) begin
            n_vec++;
            if (cyc != ge.cyc) begin
              n_err++;
              $display("FAIL gnt_cycle: got cycle %0d, required %0d", cyc, ge.cyc);
            end
          end
          gnt_cyc = cyc;
        end
      end else if (o_m_req) begin
        n_vec++; n_err++;
        $display("FAIL mreq_stray: got o_m_req=1 without o_gnt, required 0");
      end
      if (o_done != '0) begin
        if (dq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL done_unexpected: got o_done=%b, required none", o_done);
        end else begin
          de = dq.pop_front();
          oh = NP'(1) << de.port;
          n_vec += 2;
          if (o_done !== oh || o_err !== de.err || o_rdata !== de.rdata) begin
            n_err++;
            $display("FAIL done_port%0d: got done=%b err=%b rdata=%h, required done=%b err=%b rdata=%h",
                     de.port, o_done, o_err, o_rdata, oh, de.err, de.rdata);
          end
          if (cyc - gnt_cyc != de.lat) begin
            n_err++;
            $display("FAIL done_latency: got %0d cycles after grant, required %0d", cyc - gnt_cyc, de.lat);
          end
        end
      end else if (o_err) begin
        n_vec++; n_err++;
        $display("FAIL err_stray: got o_err=1 without o_done, required 0");
      end
    end
  end

  task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pwr[p] = wr; paddr[p] = a; pwdata[p] = d;
  endtask

  // Expect one access from port p; lat = grant-to-done cycles
  task automatic exp_acc(input int p, input int lat, input logic err, input int gcyc = -1);
    gnt_t  g;
    done_t d;
    g.port = p; g.wr = pwr[p]; g.addr = paddr[p]; g.wdata = pwdata[p]; g.cyc = gcyc;
    if (!err && !pwr[p]) last_rd = 16'h0A00 + DW'(paddr[p][7:0]);
    d.port = p; d.err = err; d.rdata = last_rd; d.lat = lat;
    gq.push_back(g);
    dq.push_back(d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((gq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (gq.size() != 0 || dq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d grants and %0d dones outstanding, required 0", gq.size(), dq.size());
      gq.delete();
      dq.delete();
    end
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    i_rst_n = 1'b0; i_req = '0; i_wr = '0; i_lock = '0; i_addr = '0; i_wdata = '0;
    i_m_wait = 1'b0; i_m_valid = 1'b0; i_m_rdata = '0; last_rd = '0;
    for (int k = 0; k < NP; k++) set_port(k, 1'b0, 20'h50000 + AW'(k), 16'h1110 + DW'(k));
    repeat (3) @(negedge i_clk);
    n_vec++;
    if ({o_gnt, o_done, o_err, o_rdata, o_busy, o_m_req, o_m_wr, o_m_addr, o_m_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got gnt=%b done=%b busy=%b mreq=%b addr=%h rdata=%h, required all 0",
               o_gnt, o_done, o_busy, o_m_req, o_m_addr, o_rdata);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // All ports reading continuously: 0,1,2,0,1,2
    ctl_lat = 3;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) exp_acc(p, 4, 1'b0);
    for (int k = 0; k < NP; k++) left[k] = 2;
    drain(200);

    // Core write, controller answers 8 cycles after the request
    set_port(PORT_CORE, 1'b1, 20'h00123, 16'hBEEF);
    ctl_lat = 8;
    exp_acc(PORT_CORE, 9, 1'b0);
    left[PORT_CORE] = 1;
    drain(100);

    // Recogniser burst lock: 8 locked grants, loader once, recogniser again
    set_port(PORT_CORE, 1'b0, 20'h50001, 16'h1111);
    ctl_lat = 2;
    i_lock[PORT_RECOG] = 1'b1;
    for (int i = 0; i < MB; i++) exp_acc(PORT_RECOG, 3, 1'b0);
    exp_acc(PORT_LOADER, 3, 1'b0);
    exp_acc(PORT_RECOG, 3, 1'b0);
    left[PORT_RECOG]  = MB + 1;
    left[PORT_LOADER] = 1;
    drain(400);
    i_lock = '0;

    // Controller silent: timeout with err, then a normal access
    ctl_mute = 1;
    exp_acc(PORT_LOADER, TMO + 1, 1'b1);
    left[PORT_LOADER] = 1;
    drain(100);
    ctl_mute = 0;
    ctl_lat = 3;
    exp_acc(PORT_CORE, 4, 1'b0);
    left[PORT_CORE] = 1;
    drain(100);

    // Controller busy holds off arbitration; grant one cycle after it clears
    i_m_wait = 1'b1;
    for (int k = 0; k < NP; k++) left[k] = 1;
    repeat (10) @(negedge i_clk);
    exp_acc(PORT_RECOG, 4, 1'b0, cyc + 1);
    exp_acc(PORT_LOADER, 4, 1'b0);
    exp_acc(PORT_CORE, 4, 1'b0);
    i_m_wait = 1'b0;
    drain(200);

    // Reset in WAIT drops the access; loader then wins first
    ctl_lat = 10;
    ge.port = PORT_CORE; ge.wr = 1'b0; ge.addr = paddr[PORT_CORE]; ge.wdata = pwdata[PORT_CORE]; ge.cyc = -1;
    gq.push_back(ge);
    left[PORT_CORE] = 1;
    drain(100);
    left[PORT_LOADER] = 1;
    left[PORT_RECOG]  = 1;
    i_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_gnt, o_done, o_err, o_rdata, o_busy, o_m_req, o_m_wr, o_m_addr, o_m_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got gnt=%b done=%b busy=%b mreq=%b addr=%h rdata=%h, required all 0",
               o_gnt, o_done, o_busy, o_m_req, o_m_addr, o_rdata);
    end
    last_rd = '0;
    repeat (2) @(negedge i_clk);
    exp_acc(PORT_LOADER, 11, 1'b0);
    exp_acc(PORT_RECOG, 11, 1'b0);
    i_rst_n = 1'b1;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single off-chip SRAM controller between NPORTS requesters: image loader (write), core (read/write) and letter-recognition fetch engine (read bursts).
- Sits between the requesters and the SRAM controller's core-side interface (request, wr, addr, wdata, wait, valid, rdata).
- Serialises accesses with round-robin arbitration, optional per-port burst lock bounded by MAX_BURST, and a per-access timeout.

Parameters:
NPORTS, 3, number of requester ports (port 0 = loader, 1 = core, 2 = recogniser)
AW, 20, SRAM word address width
DW, 16, SRAM data width
TIMEOUT, 16, cycles in WAIT before an access is aborted with error
MAX_BURST, 8, maximum consecutive locked grants to one port

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_req  input  NPORTS  per-port access request, level, held until grant
i_wr  input  NPORTS  per-port direction, 1 = write, 0 = read
i_lock  input  NPORTS  per-port burst lock request
i_addr  input  NPORTS*AW  per-port address, port k at [k*AW +: AW]
i_wdata  input  NPORTS*DW  per-port write data
o_gnt  output  NPORTS  one-hot, 1-cycle pulse: access accepted, inputs latched
o_done  output  NPORTS  one-hot, 1-cycle pulse: access finished
o_err  output  1  valid with o_done: access timed out
o_rdata  output  DW  read data, valid with o_done
o_busy  output  1  arbiter not in IDLE
o_m_req  output  1  1-cycle request pulse to SRAM controller
o_m_wr  output  1  direction to controller, 1 = write
o_m_addr  output  AW  address to controller
o_m_wdata  output  DW  write data to controller
i_m_wait  input  1  controller busy
i_m_valid  input  1  controller access complete, 1-cycle pulse
i_m_rdata  input  DW  controller read data, valid with i_m_valid

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = NPORTS-1, so port 0 has first priority; lock owner invalid; burst count 0; timeout count 0.
- Reset mid-access forces IDLE immediately; the in-flight access is dropped and no o_done is produced.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitrates only when i_m_wait==0 and any i_req is high.
  - Winner is the lock owner if the lock is valid, that owner's i_req is high and burst count < MAX_BURST.
  - Otherwise the winner is the first requester scanning ptr+1, ptr+2, ... modulo NPORTS.
  - The winner's wr, addr and wdata are latched. Next state is ISSUE.
- ISSUE:
  - o_gnt[winner]=1 and o_m_req=1 for exactly this cycle.
  - o_m_wr, o_m_addr and o_m_wdata are driven from the latches and held stable through WAIT.
  - ptr <= winner. Next state is WAIT.
  - The requester may drop or change its inputs from the next cycle.
- WAIT:
  - The timeout counter increments each cycle.
  - On i_m_valid: capture i_m_rdata into o_rdata (reads only; writes leave o_rdata unchanged), clear err, go to DONE.
  - If the counter reaches TIMEOUT-1 without i_m_valid: set err, go to DONE.
  - If i_m_valid and the timeout occur in the same cycle, valid wins and err=0.
- DONE:
  - o_done[winner]=1 and o_err=err for this cycle. Timeout counter cleared. Next state is IDLE.
  - Lock update:
    - winner's i_lock high and winner == current owner: burst count += 1.
    - winner's i_lock high and winner is a new owner: owner = winner, burst count = 1.
    - winner's i_lock low: lock invalid, burst count 0.
  - Once burst count reaches MAX_BURST, the lock is bypassed for one arbitration and burst count resets to 0. This guarantees other ports service.
- Latency: request seen in IDLE at cycle t gives o_gnt and o_m_req at t+1. i_m_valid at cycle v gives o_done at v+1. Minimum back-to-back spacing is 4 cycles plus controller latency.
- A stray i_m_valid outside WAIT is ignored.
- i_req deasserted before grant is legal; that port is simply not chosen.
- Simultaneous requests from all ports with no lock: grant order 0,1,2,0,...
- Width rules: timeout counter is $clog2(TIMEOUT) bits. Burst count is $clog2(MAX_BURST+1) bits. Pointer arithmetic wraps modulo NPORTS.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - port index constants PORT_LOADER=0, PORT_CORE=1, PORT_RECOG=2
  - default AW/DW localparams
- One sub-module, rr_picker: combinational round-robin one-hot selector taking request vector and pointer, returning one-hot grant and index.
- FSM, latches, lock and timeout logic stay in sram_port_arbiter.

Test Plan:
1. Port 1 write, addr 0x00123, wdata 0xBEEF; controller returns valid 8 cycles after o_m_req -> o_gnt=3'b010 one cycle with o_m_req, o_m_wr=1, o_m_addr=0x00123, o_m_wdata=0xBEEF; o_done=3'b010 one cycle after valid, o_err=0.
2. Ports 0,1,2 all requesting reads continuously, no lock -> grant sequence 0,1,2,0,1,2; each o_rdata equals controller-returned value (0x0A00+port).
3. Port 2 holds i_lock and i_req, port 0 also requesting -> port 2 granted 8 times consecutively, port 0 on the 9th arbitration, then port 2 again.
4. Controller never asserts i_m_valid -> o_done pulses exactly TIMEOUT+1 cycles after o_m_req with o_err=1; the next request proceeds normally.
5. i_m_wait held high with all ports requesting -> no o_gnt and no o_m_req until i_m_wait falls; grant issues one cycle later.
6. i_rst_n asserted during WAIT -> all outputs 0 immediately; after release, a pending port 0 request is granted first.
